// File: rtl/alarm_pwm_ctrl.sv
// Three-level temperature alarm driver: per-period ADC classification with
// hysteresis and a consecutive-tick filter, latched ALARM, and a level-dependent PWM.
module alarm_pwm_ctrl #(
  parameter int DATA_W   = 8,
  parameter int PERIOD   = 233001,
  parameter int IDLE_ON  = 20,
  parameter int ALARM_ON = 230000,
  parameter int WARN_TH  = 50,
  parameter int ALARM_TH = 60,
  parameter int HYST     = 2,
  parameter int FILT_PER = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] adc,
  input  logic              ack,
  output logic              pwm,
  output logic [1:0]        level,
  output logic              tick
);

  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int FCNT_W = (FILT_PER > 1) ? $clog2(FILT_PER) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_PER - 1);
  localparam logic [DATA_W-1:0] A_HI      = DATA_W'(ALARM_TH);
  localparam logic [DATA_W-1:0] A_LO      = DATA_W'(ALARM_TH - HYST);
  localparam logic [DATA_W-1:0] W_HI      = DATA_W'(WARN_TH);
  localparam logic [DATA_W-1:0] W_LO      = DATA_W'(WARN_TH - HYST);
  localparam logic [31:0]       IDLE_ON_U  = 32'(IDLE_ON);
  localparam logic [31:0]       ALARM_ON_U = 32'(ALARM_ON);

  localparam logic [1:0] L_IDLE  = 2'd0;
  localparam logic [1:0] L_WARN  = 2'd1;
  localparam logic [1:0] L_ALARM = 2'd2;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        level_q, level_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              ack_flag_q, ack_flag_d;
  logic              phase_q, phase_d;

  logic              is_tick;
  logic              ack_eff;
  logic [1:0]        cand;
  logic [31:0]       cnt_ext;

  assign is_tick = (cnt_q == CNT_LAST);
  assign cnt_ext = 32'(cnt_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      level_q    <= L_IDLE;
      fcnt_q     <= '0;
      ack_flag_q <= 1'b0;
      phase_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      fcnt_q     <= fcnt_d;
      ack_flag_q <= ack_flag_d;
      phase_q    <= phase_d;
    end
  end

  always_comb begin
    cnt_d   = is_tick ? '0 : cnt_q + 1'b1;
    // An ack arriving on the tick cycle itself must release the latch for that tick.
    ack_eff = ack_flag_q | (ack & (level_q == L_ALARM));

    if (adc >= A_HI)                              cand = L_ALARM;
    else if ((level_q == L_ALARM) && (adc >= A_LO)) cand = L_ALARM;
    else if (adc >= W_HI)                         cand = L_WARN;
    else if ((level_q != L_IDLE) && (adc >= W_LO))  cand = L_WARN;
    else                                          cand = L_IDLE;

    level_d    = level_q;
    fcnt_d     = fcnt_q;
    phase_d    = phase_q;
    ack_flag_d = ack_eff;

    if (is_tick) begin
      if (cand == level_q) begin
        fcnt_d = '0;
      end else if (cand == L_ALARM) begin
        level_d = L_ALARM;
        fcnt_d  = '0;
      end else if ((level_q == L_ALARM) && !ack_eff) begin
        fcnt_d = '0;
      end else if (fcnt_q == FCNT_LAST) begin
        level_d = cand;
        fcnt_d  = '0;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
      // A level change restarts the WARN alternation on a long period.
      phase_d = (level_d != level_q) ? 1'b0 : ~phase_q;
    end

    if (level_d != L_ALARM) ack_flag_d = 1'b0;
  end

  always_comb begin
    tick  = is_tick;
    level = level_q;
    case (level_q)
      L_ALARM: pwm = (cnt_ext < ALARM_ON_U);
      L_WARN:  pwm = phase_q ? (cnt_ext < IDLE_ON_U) : (cnt_ext < ALARM_ON_U);
      default: pwm = (cnt_ext < IDLE_ON_U);
    endcase
  end

endmodule

// File: doc/alarm_pwm_ctrl.md
# alarm_pwm_ctrl

Parametrised three-level alarm driver for the refrigeration controller. It samples the temperature ADC code once per PWM period and classifies it as IDLE, WARN or ALARM, with hysteresis and a consecutive-sample filter. It drives a buzzer/lamp PWM whose pattern depends on the level. ALARM is latched until the operator acknowledges it and the temperature has recovered.

## Interface
Parameters:
- DATA_W, 8: ADC code width (unsigned).
- PERIOD, 233001: PWM period in clk cycles; counter runs 0..PERIOD-1.
- IDLE_ON, 20: high cycles per period in IDLE, and in WARN odd periods.
- ALARM_ON, 230000: high cycles per period in ALARM, and in WARN even periods.
- WARN_TH, 50: WARN entry threshold (code >= WARN_TH).
- ALARM_TH, 60: ALARM entry threshold (code >= ALARM_TH).
- HYST, 2: hysteresis in codes for leaving a level.
- FILT_PER, 4: consecutive periods required for a non-immediate level change.
- Legal ranges: 0 < IDLE_ON < ALARM_ON <= PERIOD, HYST <= WARN_TH < ALARM_TH < 2^DATA_W, FILT_PER >= 1.

Ports:
- clk in 1: clock.
- reset in 1: reset, asynchronous, active-high.
- adc in DATA_W: temperature code, unsigned; sampled only on tick cycles.
- ack in 1: operator acknowledge, one-cycle or longer pulse.
- pwm out 1: buzzer/lamp drive.
- level out 2: current level: 0 IDLE, 1 WARN, 2 ALARM; 3 never appears.
- tick out 1: high for the one cycle where cnt == PERIOD-1.

## Operation
- Period counter cnt: increments every clk and wraps from PERIOD-1 to 0. Its width is ceil(log2(PERIOD)).
- Classification of adc on a tick, using the current level L. The first matching rule applies:
  - adc >= ALARM_TH gives ALARM.
  - L==ALARM and adc >= ALARM_TH-HYST gives ALARM.
  - adc >= WARN_TH gives WARN.
  - L>=WARN and adc >= WARN_TH-HYST gives WARN.
  - Otherwise IDLE.
- Level update, evaluated on tick cycles only, with candidate C and filter count fcnt:
  - C==L: fcnt <= 0.
  - C==ALARM and L!=ALARM: level <= ALARM immediately, fcnt <= 0. This path is unfiltered (safety).
  - L==ALARM, C<ALARM and ack_flag==0: level held, fcnt <= 0.
  - Otherwise fcnt increments. When fcnt reaches FILT_PER-1, level <= C and fcnt <= 0. If C changes value between ticks while still != L, counting continues and the latest C is adopted.
- ack_flag: set on any cycle with ack==1 while level==ALARM. Cleared when level leaves ALARM. ack is ignored in IDLE and WARN. An ack on the tick cycle itself counts for that tick.
- phase bit: toggles every tick. It is forced to 0 on any tick where level changes, so the first WARN period is a long one.
- pwm is a combinational decode of registered state only (no input feed-through):
  - IDLE: cnt < IDLE_ON.
  - ALARM: cnt < ALARM_ON.
  - WARN: cnt < ALARM_ON when phase==0, cnt < IDLE_ON when phase==1.

## Timing
- Reset values: cnt=0, level=0, fcnt=0, ack_flag=0, phase=0, tick=0. pwm=1, as the IDLE decode at cnt=0.
- adc is captured at the rising edge ending the tick cycle. Level, fcnt and phase update on that same edge. The new pattern starts at cnt=0 of the following period, so there is no mid-period pattern change.
- Latency from adc crossing ALARM_TH to the level change is at most PERIOD cycles, bounded by the next tick.
- Latency for a filtered change is FILT_PER consecutive ticks.
- Reset mid-operation aborts everything immediately, including a latched ALARM and ack_flag. The block restarts as IDLE at cnt=0.
- adc must be stable in the tick cycle; other cycles are don't-care.

## Test plan
Bench parameters: PERIOD=100, IDLE_ON=2, ALARM_ON=90, WARN_TH=50, ALARM_TH=60, HYST=2, FILT_PER=3.
- Reset, then adc=0 for 5 periods -> level=0, pwm high exactly cycles 0-1 of every 100, tick once per 100 cycles.
- adc=60 at one tick -> level=2 on that edge, pwm high 90 of the next 100 cycles; adc=59 then keeps ALARM (hysteresis).
- In ALARM, adc=40 for 5 ticks with no ack -> level stays 2. Then an ack pulse is given -> level=0 after 3 further consecutive ticks, and ack_flag clears.
- From WARN, adc=49 for 5 ticks -> level stays 1. Then adc=47 for 3 ticks -> level=0.
- From IDLE, adc=55 for 3 ticks -> level=1. Then pwm alternates 90-high, 2-high, 90-high periods. An ack in WARN has no effect.
- Reset asserted at cnt=37 during ALARM -> pwm=1, level=0, cnt=0 asynchronously. After release, the IDLE pattern resumes.
